// File: rtl/sram_frame_arbiter.sv
// rtl/sram_frame_arbiter.sv - shares the 16-bit SRAM port between display reads and frame writes
module sram_frame_arbiter #(
  parameter int ADDR_WIDTH   = 20,
  parameter int READ_CYCLES  = 2,
  parameter int WRITE_CYCLES = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rd_req,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic                  o_rd_grant,
  output logic [15:0]           o_rd_data,
  output logic                  o_rd_valid,
  input  logic                  i_wr_req,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [15:0]           i_wr_data,
  output logic                  o_wr_grant,
  output logic                  o_wr_ack,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  output logic [15:0]           o_sram_dq_out,
  output logic                  o_sram_dq_oe,
  input  logic [15:0]           i_sram_dq,
  output logic                  o_sram_ce_n,
  output logic                  o_sram_oe_n,
  output logic                  o_sram_we_n,
  output logic                  o_sram_lb_n,
  output logic                  o_sram_ub_n
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RD     = 2'd1;
  localparam logic [1:0] ST_WR     = 2'd2;
  localparam logic [1:0] ST_WR_REC = 2'd3;

  localparam logic [2:0] RD_LAST    = 3'(READ_CYCLES - 1);
  localparam logic [2:0] WR_LAST    = 3'(WRITE_CYCLES - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [1:0] state;
  logic [2:0] phase_cnt;
  logic [3:0] starve_cnt;
  logic       at_limit;
  logic       rd_win;
  logic       wr_win;

  // Reads win by default; the writer only overtakes once it has watched STARVE_LIMIT reads go by.
  always_comb begin
    at_limit   = (starve_cnt == STARVE_MAX);
    rd_win     = i_rd_req && (!i_wr_req || !at_limit);
    wr_win     = i_wr_req && (!i_rd_req || at_limit);
    o_rd_grant = !i_rst && (state == ST_IDLE) && rd_win;
    o_wr_grant = !i_rst && (state == ST_IDLE) && wr_win;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= ST_IDLE;
      phase_cnt     <= 3'd0;
      starve_cnt    <= 4'd0;
      o_sram_ce_n   <= 1'b1;
      o_sram_oe_n   <= 1'b1;
      o_sram_we_n   <= 1'b1;
      o_sram_lb_n   <= 1'b1;
      o_sram_ub_n   <= 1'b1;
      o_sram_dq_oe  <= 1'b0;
      o_sram_addr   <= '0;
      o_sram_dq_out <= 16'h0000;
      o_rd_data     <= 16'h0000;
      o_rd_valid    <= 1'b0;
      o_wr_ack      <= 1'b0;
    end else begin
      o_rd_valid <= 1'b0;
      o_wr_ack   <= 1'b0;
      case (state)
        ST_IDLE: begin
          phase_cnt <= 3'd0;
          if (o_wr_grant || !i_wr_req) begin
            starve_cnt <= 4'd0;
          end else if (o_rd_grant && !at_limit) begin
            starve_cnt <= starve_cnt + 4'd1;
          end
          if (o_rd_grant) begin
            state       <= ST_RD;
            o_sram_addr <= i_rd_addr;
            o_sram_ce_n <= 1'b0;
            o_sram_oe_n <= 1'b0;
            o_sram_lb_n <= 1'b0;
            o_sram_ub_n <= 1'b0;
          end else if (o_wr_grant) begin
            state         <= ST_WR;
            o_sram_addr   <= i_wr_addr;
            o_sram_dq_out <= i_wr_data;
            o_sram_dq_oe  <= 1'b1;
            o_sram_ce_n   <= 1'b0;
            o_sram_we_n   <= 1'b0;
            o_sram_lb_n   <= 1'b0;
            o_sram_ub_n   <= 1'b0;
          end
        end
        ST_RD: begin
          if (phase_cnt == RD_LAST) begin
            state       <= ST_IDLE;
            o_rd_data   <= i_sram_dq;
            o_rd_valid  <= 1'b1;
            o_sram_oe_n <= 1'b1;
            o_sram_ce_n <= 1'b1;
            o_sram_lb_n <= 1'b1;
            o_sram_ub_n <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt + 3'd1;
          end
        end
        ST_WR: begin
          // Data and dq_oe stay up one cycle past the WE_n rising edge to cover hold time.
          if (phase_cnt == WR_LAST) begin
            state       <= ST_WR_REC;
            o_sram_we_n <= 1'b1;
            o_wr_ack    <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt + 3'd1;
          end
        end
        ST_WR_REC: begin
          state        <= ST_IDLE;
          o_sram_dq_oe <= 1'b0;
          o_sram_ce_n  <= 1'b1;
          o_sram_lb_n  <= 1'b1;
          o_sram_ub_n  <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_frame_arbiter.sv
// tb/tb_sram_frame_arbiter.sv - directed checks on default parameters plus a random protocol run
module tb_sram_frame_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          errors = 0;

  logic        rd_req, rd_grant, rd_valid, wr_req, wr_grant, wr_ack;
  logic [19:0] rd_addr, wr_addr, sram_addr;
  logic [15:0] rd_data, wr_data, sram_dq_out, sram_dq;
  logic        dq_oe, ce_n, oe_n, we_n, lb_n, ub_n;

  logic        rd_req_b, rd_grant_b, rd_valid_b, wr_req_b, wr_grant_b, wr_ack_b;
  logic [19:0] rd_addr_b, wr_addr_b, sram_addr_b;
  logic [15:0] rd_data_b, wr_data_b, sram_dq_out_b, sram_dq_b;
  logic        dq_oe_b, ce_n_b, oe_n_b, we_n_b, lb_n_b, ub_n_b;

  logic [15:0] mem [0:255];

  always #5 clk = ~clk;

  sram_frame_arbiter dut (
    .i_clk(clk), .i_rst(rst),
    .i_rd_req(rd_req), .i_rd_addr(rd_addr), .o_rd_grant(rd_grant),
    .o_rd_data(rd_data), .o_rd_valid(rd_valid),
    .i_wr_req(wr_req), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .o_wr_grant(wr_grant), .o_wr_ack(wr_ack),
    .o_sram_addr(sram_addr), .o_sram_dq_out(sram_dq_out), .o_sram_dq_oe(dq_oe),
    .i_sram_dq(sram_dq), .o_sram_ce_n(ce_n), .o_sram_oe_n(oe_n),
    .o_sram_we_n(we_n), .o_sram_lb_n(lb_n), .o_sram_ub_n(ub_n)
  );

  sram_frame_arbiter #(.READ_CYCLES(1), .WRITE_CYCLES(3)) dut_b (
    .i_clk(clk), .i_rst(rst),
    .i_rd_req(rd_req_b), .i_rd_addr(rd_addr_b), .o_rd_grant(rd_grant_b),
    .o_rd_data(rd_data_b), .o_rd_valid(rd_valid_b),
    .i_wr_req(wr_req_b), .i_wr_addr(wr_addr_b), .i_wr_data(wr_data_b),
    .o_wr_grant(wr_grant_b), .o_wr_ack(wr_ack_b),
    .o_sram_addr(sram_addr_b), .o_sram_dq_out(sram_dq_out_b), .o_sram_dq_oe(dq_oe_b),
    .i_sram_dq(sram_dq_b), .o_sram_ce_n(ce_n_b), .o_sram_oe_n(oe_n_b),
    .o_sram_we_n(we_n_b), .o_sram_lb_n(lb_n_b), .o_sram_ub_n(ub_n_b)
  );

  // SRAM model: 256 words on the low address bits, preloaded while reset is high.
  always @(posedge clk) begin
    if (rst) mem[8'h23] <= 16'hA5C3;
    else if (!ce_n && !we_n) mem[sram_addr[7:0]] <= sram_dq_out;
  end
  assign sram_dq   = (!ce_n && !oe_n) ? mem[sram_addr[7:0]] : 16'h0000;
  assign sram_dq_b = ~sram_addr_b[15:0];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_read(input logic [19:0] a, input logic [15:0] exp, input string tag);
    int lat;
    rd_req = 1'b1; rd_addr = a;
    #1 check({tag, "_grant"}, rd_grant, 1);
    lat = 0;
    do begin
      @(negedge clk);
      rd_req = 1'b0;
      lat++;
    end while (!rd_valid && lat < 10);
    check({tag, "_latency"}, lat, 3);
    check({tag, "_data"}, rd_data, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq[6];
    int n, wr_seen, we_low, oe_hi, ack_at;
    int out_rd, out_wr, n_rd, n_wr;
    logic rd_got, wr_got;
    logic [15:0] exp_rd;

    rst = 1'b1;
    rd_req = 0; rd_addr = '0; wr_req = 0; wr_addr = '0; wr_data = '0;
    rd_req_b = 0; rd_addr_b = '0; wr_req_b = 0; wr_addr_b = '0; wr_data_b = '0;
    repeat (3) @(negedge clk);

    // Reset values, and grants held off while reset is asserted.
    check("rst_ce_n", ce_n, 1);
    check("rst_oe_n", oe_n, 1);
    check("rst_we_n", we_n, 1);
    check("rst_lb_ub", {lb_n, ub_n}, 2'b11);
    check("rst_dq_oe", dq_oe, 0);
    check("rst_addr", sram_addr, 0);
    check("rst_dq_out", sram_dq_out, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_valid_ack", {rd_valid, wr_ack}, 2'b00);
    rd_req = 1'b1; rd_addr = 20'h00123;
    #1 check("rst_gate_rd", rd_grant, 0);

    // Test 1: first read of 0x00123.
    rst = 1'b0;
    #1 check("t1_grant", rd_grant, 1);
    @(negedge clk);
    rd_req = 1'b0;
    check("t1_c1_strobes", {ce_n, oe_n, we_n, dq_oe}, 4'b0010);
    check("t1_c1_addr", sram_addr, 20'h00123);
    check("t1_c1_valid", rd_valid, 0);
    @(negedge clk);
    check("t1_c2_oe_n", oe_n, 0);
    check("t1_c2_valid", rd_valid, 0);
    @(negedge clk);
    check("t1_c3_valid", rd_valid, 1);
    check("t1_c3_data", rd_data, 16'hA5C3);
    check("t1_c3_strobes", {ce_n, oe_n}, 2'b11);
    @(negedge clk);
    check("t1_c4_valid", rd_valid, 0);
    check("t1_c4_hold", rd_data, 16'hA5C3);

    // Test 2: write 0x1234 to 0x40, then read it back.
    wr_req = 1'b1; wr_addr = 20'h00040; wr_data = 16'h1234;
    #1 check("t2_grant", wr_grant, 1);
    check("t2_no_rd_grant", rd_grant, 0);
    we_low = 0; oe_hi = 0; ack_at = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      wr_req = 1'b0;
      if (!we_n) we_low++;
      if (dq_oe) oe_hi++;
      if (wr_ack) ack_at = k;
      if (k == 1) check("t2_dq_out", sram_dq_out, 16'h1234);
      if (k == 3) check("t2_rec_ce_n", ce_n, 0);
    end
    check("t2_we_low_cycles", we_low, 2);
    check("t2_dq_oe_cycles", oe_hi, 3);
    check("t2_ack_cycle", ack_at, 3);
    check("t2_model_word", mem[8'h40], 16'h1234);
    do_read(20'h00040, 16'h1234, "t2_readback");

    // Test 3: read held continuously, write pending -> four reads, one write, reads resume.
    rd_req = 1'b1; rd_addr = 20'h00023;
    wr_req = 1'b1; wr_addr = 20'h00060; wr_data = 16'hBEEF;
    n = 0; wr_seen = 0;
    for (int c = 0; c < 60 && n < 6; c++) begin
      if (c > 0) @(negedge clk);
      if (wr_seen == 1) begin
        check("t3_starve_clr", dut.starve_cnt, 0);
        wr_req = 1'b0;
        wr_seen = 2;
      end
      #1;
      if (rd_grant && n < 6) begin seq[n] = 1; n++; end
      if (wr_grant && n < 6) begin seq[n] = 2; n++; wr_seen = 1; end
    end
    check("t3_grant_count", n, 6);
    check("t3_g0", seq[0], 1);
    check("t3_g3", seq[3], 1);
    check("t3_g4_write", seq[4], 2);
    check("t3_g5_resume", seq[5], 1);
    @(negedge clk);
    rd_req = 1'b0;
    repeat (3) @(negedge clk);

    // Test 4: simultaneous requests with the counter at zero.
    rd_req = 1'b1; rd_addr = 20'h00040;
    wr_req = 1'b1; wr_addr = 20'h00070; wr_data = 16'h7777;
    #1 check("t4_rd_first", {rd_grant, wr_grant}, 2'b10);
    @(negedge clk);
    rd_req = 1'b0;
    @(negedge clk);
    check("t4_no_grant_rd", wr_grant, 0);
    @(negedge clk);
    check("t4_valid", rd_valid, 1);
    check("t4_data", rd_data, 16'h1234);
    check("t4_wr_next", wr_grant, 1);
    @(negedge clk);
    wr_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t4_ack", wr_ack, 1);
    @(negedge clk);

    // Test 5: reset during the second WR cycle.
    wr_req = 1'b1; wr_addr = 20'h00055; wr_data = 16'hDEAD;
    #1 check("t5_grant", wr_grant, 1);
    @(negedge clk);
    wr_req = 1'b0;
    @(negedge clk);
    check("t5_we_low", we_n, 0);
    rst = 1'b1;
    @(negedge clk);
    check("t5_abort_pins", {we_n, dq_oe, ce_n}, 3'b101);
    check("t5_abort_ack", wr_ack, 0);
    check("t5_abort_state", dut.state, 0);
    rst = 1'b0;
    @(negedge clk);
    check("t5_no_late_ack", wr_ack, 0);
    do_read(20'h00023, 16'hA5C3, "t5_read");

    // Test 6: random traffic on the READ_CYCLES=1 / WRITE_CYCLES=3 instance.
    out_rd = 0; out_wr = 0; n_rd = 0; n_wr = 0;
    rd_got = 0; wr_got = 0; exp_rd = '0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      check("rnd_oe_we", !oe_n_b && !we_n_b, 0);
      check("rnd_dq_oe", dq_oe_b && !oe_n_b, 0);
      if (rd_valid_b) begin
        check("rnd_rd_match", out_rd, 1);
        check("rnd_rd_data", rd_data_b, exp_rd);
        out_rd--;
      end
      if (wr_ack_b) begin
        check("rnd_wr_match", out_wr, 1);
        out_wr--;
      end
      if (rd_got) begin rd_req_b = 0; rd_got = 0; end
      if (wr_got) begin wr_req_b = 0; wr_got = 0; end
      if (i < 9980) begin
        if (!rd_req_b && $urandom_range(0, 2) == 0) begin
          rd_req_b = 1; rd_addr_b = 20'($urandom);
        end else if (rd_req_b && $urandom_range(0, 15) == 0) rd_req_b = 0;
        if (!wr_req_b && $urandom_range(0, 2) == 0) begin
          wr_req_b = 1; wr_addr_b = 20'($urandom); wr_data_b = 16'($urandom);
        end else if (wr_req_b && $urandom_range(0, 15) == 0) wr_req_b = 0;
      end else begin
        rd_req_b = 0; wr_req_b = 0;
      end
      #1;
      if (rd_grant_b || wr_grant_b) begin
        check("rnd_grant_free", out_rd + out_wr, 0);
        check("rnd_one_grant", rd_grant_b && wr_grant_b, 0);
      end
      if (rd_grant_b) begin out_rd++; n_rd++; exp_rd = ~rd_addr_b[15:0]; rd_got = 1; end
      if (wr_grant_b) begin out_wr++; n_wr++; wr_got = 1; end
    end
    check("rnd_rd_drained", out_rd, 0);
    check("rnd_wr_drained", out_wr, 0);
    check("rnd_rd_activity", n_rd > 100, 1);
    check("rnd_wr_activity", n_wr > 100, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
